dmac_ch_priority_arb: RTL and testbench

DMAC_CH_PRIORITY_ARB -- requirements
Module: dmac_ch_priority_arb

---
 rtl/dmac_ch_priority_arb.sv | 141 ++++++++++++++
 tb/tb_dmac_ch_priority_arb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_ch_priority_arb.sv
// Priority arbiter for DMA channels: the highest-priority requester wins, ties are
// broken round-robin after the last released channel, and a grant is held until done or abort.
module dmac_ch_priority_arb #(
    parameter int NUM_CH    = 8,
    parameter int PRI_WIDTH = 3,
    parameter int IDX_WIDTH = 3
) (
    input  logic                        hclk,
    input  logic                        hresetn,
    input  logic                        arb_en,
    input  logic [NUM_CH-1:0]           ch_req,
    input  logic [NUM_CH*PRI_WIDTH-1:0] ch_pri,
    input  logic                        xfer_done,
    output logic [NUM_CH-1:0]           ch_grant,
    output logic [IDX_WIDTH-1:0]        grant_idx,
    output logic                        grant_vld,
    output logic                        arb_busy
);

    // state    | meaning
    // ST_IDLE  | no grant; wait for an enabled request
    // ST_ARB   | pick the winner from this cycle's requests and priorities
    // ST_GRANT | grant held until xfer_done or the owner drops its request
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_GRANT = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_CH-1:0]    grant_q, grant_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [IDX_WIDTH-1:0] last_q, last_d;
    logic                 vld_q, vld_d;

    logic [PRI_WIDTH-1:0] max_pri;
    logic [NUM_CH-1:0]    cand;
    logic [IDX_WIDTH-1:0] win_idx;
    logic                 win_found;
    logic                 req_ok;
    logic                 release_hit;

    always_comb begin
        max_pri = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_req[i] && (ch_pri[i*PRI_WIDTH +: PRI_WIDTH] > max_pri)) begin
                max_pri = ch_pri[i*PRI_WIDTH +: PRI_WIDTH];
            end
        end
    end

    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand[i] = ch_req[i] && (ch_pri[i*PRI_WIDTH +: PRI_WIDTH] == max_pri);
        end
    end

    // Rotating search: first candidate above last_q, otherwise the lowest candidate (wrap).
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!win_found && cand[i] && (i > int'(last_q))) begin
                win_found = 1'b1;
                win_idx   = IDX_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!win_found && cand[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_WIDTH'(i);
            end
        end
    end

    assign req_ok      = arb_en && (|ch_req);
    assign release_hit = xfer_done || !(|(ch_req & grant_q));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (req_ok) begin
                    grant_d = NUM_CH'(1) << win_idx;
                    idx_d   = win_idx;
                    vld_d   = 1'b1;
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_hit) begin
                    grant_d = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                    last_d  = idx_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                idx_d   = '0;
                vld_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= IDX_WIDTH'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
        end
    end

    assign ch_grant  = grant_q;
    assign grant_idx = idx_q;
    assign grant_vld = vld_q;
    assign arb_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmac_ch_priority_arb.sv
// Bench for dmac_ch_priority_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural arbitration model.
module tb_dmac_ch_priority_arb;
    localparam int N   = 8;
    localparam int PW  = 3;
    localparam int IW  = 3;
    localparam int PRW = N * PW;
    localparam int S_IDLE  = 0;
    localparam int S_ARB   = 1;
    localparam int S_GRANT = 2;

    logic           hclk = 1'b0;
    logic           hresetn = 1'b0;
    logic           arb_en = 1'b0;
    logic           xfer_done = 1'b0;
    logic [N-1:0]   ch_req = '0;
    logic [PRW-1:0] ch_pri = '0;
    logic [N-1:0]   ch_grant;
    logic [IW-1:0]  grant_idx;
    logic           grant_vld;
    logic           arb_busy;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    dmac_ch_priority_arb #(.NUM_CH(N), .PRI_WIDTH(PW), .IDX_WIDTH(IW)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .arb_en    (arb_en),
        .ch_req    (ch_req),
        .ch_pri    (ch_pri),
        .xfer_done (xfer_done),
        .ch_grant  (ch_grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld),
        .arb_busy  (arb_busy)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner: highest priority among requesters, ties resolved by scanning upward from last+1.
    function automatic int pick(input logic [N-1:0] req, input logic [PRW-1:0] pri, input int last);
        int best;
        int c;
        best = -1;
        for (int i = 0; i < N; i++) begin
            if (((req >> i) & 1) == 1 && int'((pri >> (i*PW)) & 7) > best)
                best = int'((pri >> (i*PW)) & 7);
        end
        for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (((req >> c) & 1) == 1 && int'((pri >> (c*PW)) & 7) == best) return c;
        end
        return 0;
    endfunction

    int           m_state;
    logic [N-1:0] m_grant;
    int           m_idx;
    int           m_last;
    logic         m_vld;

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            m_state <= S_IDLE;
            m_grant <= '0;
            m_idx   <= 0;
            m_vld   <= 1'b0;
            m_last  <= N - 1;
        end else begin
            case (m_state)
                S_IDLE: if (arb_en && ch_req != 0) m_state <= S_ARB;
                S_ARB: begin
                    if (arb_en && ch_req != 0) begin
                        m_idx   <= pick(ch_req, ch_pri, m_last);
                        m_grant <= N'(1) << pick(ch_req, ch_pri, m_last);
                        m_vld   <= 1'b1;
                        m_state <= S_GRANT;
                    end else begin
                        m_state <= S_IDLE;
                    end
                end
                default: begin
                    if (xfer_done || ((ch_req >> m_idx) & 1) == 0) begin
                        m_grant <= '0;
                        m_idx   <= 0;
                        m_vld   <= 1'b0;
                        m_last  <= m_idx;
                        m_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always @(negedge hclk) begin
        if (chk_en) begin
            chk("ch_grant", 32'(ch_grant), 32'(m_grant));
            chk("grant_idx", 32'(grant_idx), 32'(m_idx));
            chk("grant_vld", 32'(grant_vld), 32'(m_vld));
            chk("arb_busy", 32'(arb_busy), 32'(m_state != S_IDLE));
            chk("onehot0", 32'($onehot0(ch_grant)), 32'd1);
            chk("grant_outside_GRANT", 32'(ch_grant != 0 && m_state != S_GRANT), 32'd0);
        end
    end

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        step();
        hresetn = 1'b0;
        step();
        hresetn = 1'b1;
    endtask

    task automatic wait_grant();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge hclk);
            if (grant_vld === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic done_pulse();
        step();
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk_en = 1'b1;
        @(negedge hclk);
        chk("rst_grant", 32'(ch_grant), 32'h0);
        chk("rst_idx", 32'(grant_idx), 32'h0);
        chk("rst_vld", 32'(grant_vld), 32'h0);
        chk("rst_busy", 32'(arb_busy), 32'h0);
        step();
        hresetn = 1'b1;

        // Priority wins over index, grant appears two cycles after the request.
        ch_pri = '0;
        ch_pri[0*PW +: PW] = 3'd1;
        ch_pri[2*PW +: PW] = 3'd6;
        ch_req = 8'h05;
        arb_en = 1'b1;
        step();
        @(negedge hclk);
        chk("n1_busy", 32'(arb_busy), 32'd1);
        chk("n1_no_grant", 32'(ch_grant), 32'h0);
        step();
        @(negedge hclk);
        chk("n2_grant", 32'(ch_grant), 32'h04);
        chk("n2_idx", 32'(grant_idx), 32'd2);
        chk("n2_vld", 32'(grant_vld), 32'd1);
        ch_req = 8'h00;
        done_pulse();

        // Equal priorities rotate 0..7 then wrap to 0.
        do_reset();
        ch_pri = {N{3'd3}};
        ch_req = 8'hFF;
        for (int j = 0; j < 9; j++) begin
            wait_grant();
            chk("rr_order", 32'(grant_idx), 32'(j % N));
            done_pulse();
        end
        ch_req = 8'h00;

        // No preemption while a grant is held.
        do_reset();
        ch_pri = '0;
        ch_pri[1*PW +: PW] = 3'd5;
        ch_pri[7*PW +: PW] = 3'd1;
        ch_req = 8'h82;
        wait_grant();
        chk("pre_idx", 32'(grant_idx), 32'd1);
        step();
        ch_pri[7*PW +: PW] = 3'd7;
        step();
        step();
        @(negedge hclk);
        chk("no_preempt", 32'(grant_idx), 32'd1);
        done_pulse();
        wait_grant();
        chk("after_done", 32'(grant_idx), 32'd7);
        step();
        ch_req = 8'h00;
        step();

        // Abort by request drop, pending channel granted two cycles later.
        do_reset();
        ch_pri = '0;
        ch_pri[4*PW +: PW] = 3'd4;
        ch_req = 8'h10;
        wait_grant();
        chk("abort_pre", 32'(grant_idx), 32'd4);
        step();
        ch_req = 8'h30;
        step();
        @(negedge hclk);
        chk("abort_hold", 32'(ch_grant), 32'h10);
        step();
        ch_req = 8'h20;
        step();
        @(negedge hclk);
        chk("abort_grant0", 32'(ch_grant), 32'h0);
        chk("abort_idle", 32'(arb_busy), 32'd0);
        step();
        step();
        @(negedge hclk);
        chk("abort_next", 32'(ch_grant), 32'h20);
        step();
        ch_req = 8'h00;
        step();

        // Request vanishes (or arb_en drops) during the ARB cycle.
        do_reset();
        ch_req = 8'h01;
        step();
        @(negedge hclk);
        chk("arbdrop_busy", 32'(arb_busy), 32'd1);
        ch_req = 8'h00;
        step();
        @(negedge hclk);
        chk("arbdrop_idle", 32'(arb_busy), 32'd0);
        chk("arbdrop_vld", 32'(grant_vld), 32'd0);
        step();
        ch_req = 8'h01;
        step();
        @(negedge hclk);
        chk("ensdrop_busy", 32'(arb_busy), 32'd1);
        arb_en = 1'b0;
        step();
        @(negedge hclk);
        chk("endrop_idle", 32'(arb_busy), 32'd0);
        chk("endrop_grant", 32'(ch_grant), 32'h0);
        arb_en = 1'b1;
        ch_req = 8'h00;

        // Asynchronous reset mid-grant, then restart from channel 0 search.
        do_reset();
        ch_pri = {N{3'd2}};
        ch_req = 8'h08;
        wait_grant();
        chk("rstmid_pre", 32'(grant_idx), 32'd3);
        #2;
        hresetn = 1'b0;
        #1;
        chk("rstmid_grant", 32'(ch_grant), 32'h0);
        chk("rstmid_vld", 32'(grant_vld), 32'd0);
        chk("rstmid_busy", 32'(arb_busy), 32'd0);
        ch_req = 8'h18;
        step();
        hresetn = 1'b1;
        wait_grant();
        chk("rstmid_first", 32'(grant_idx), 32'd3);
        step();
        ch_req = 8'h00;
        step();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (hresetn == 1'b0) hresetn = 1'b1;
            else if ($urandom_range(0, 399) == 0) hresetn = 1'b0;
            arb_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) ch_req = N'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                ch_pri = PRW'($urandom);
                if ($urandom_range(0, 1) == 0) ch_pri = ch_pri & {N{3'b001}};
            end
            xfer_done = ($urandom_range(0, 4) == 0);
        end
        hresetn = 1'b1;
        xfer_done = 1'b0;
        step();
        @(negedge hclk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
